// File: rtl/ttl_latch_bus_arbiter.sv
// Round-robin sequencer sharing one 8-bit D bus across NREQ octal sync latches.
// Define TTL_ARB_VERIFY_EN to read back every write and flag mismatches on err.
module ttl_latch_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int STB_CYC = 2,
  parameter int GAP_CYC = 1
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   wr,
  input  logic [8*NREQ-1:0] din,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic [7:0]        bus_D,
  output logic [NREQ-1:0]   lat_cen,
  output logic [NREQ-1:0]   lat_OCn,
  input  logic [7:0]        bus_Q
`ifdef TTL_ARB_VERIFY_EN
  ,
  output logic              err
`endif
);

  localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAX = (STB_CYC > GAP_CYC) ? STB_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] STB_LOAD = CNT_W'(STB_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W:0]   NREQ_X   = (PTR_W + 1)'(NREQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] ARB     = 4'd1;
  localparam logic [3:0] SETUP   = 4'd2;
  localparam logic [3:0] STROBE  = 4'd3;
  localparam logic [3:0] RELEASE = 4'd4;
  localparam logic [3:0] OE      = 4'd5;
  localparam logic [3:0] SAMPLE  = 4'd6;
  localparam logic [3:0] DONE    = 4'd7;
`ifdef TTL_ARB_VERIFY_EN
  localparam logic [3:0] VERIFY  = 4'd8;
`endif

  logic [3:0]       state, state_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [PTR_W-1:0] pick;
  logic             pick_vld;
  logic [PTR_W:0]   scan;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       din_sel;
  logic [NREQ-1:0]  owner_oh_nxt;
  logic             gnt_st, cen_st, oe_st;

  // Round-robin pick: scan downward so the lowest offset from ptr wins.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    scan     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (scan >= NREQ_X) scan = scan - NREQ_X;
      if (req[scan[PTR_W-1:0]]) begin
        pick     = scan[PTR_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    din_sel = din[7:0];
    for (int i = 0; i < NREQ; i++) begin
      if (pick == PTR_W'(i)) din_sel = din[8*i +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (|req) state_nxt = ARB;
      end
      ARB: begin
        if (pick_vld) begin
          owner_nxt = pick;
          state_nxt = wr[pick] ? SETUP : OE;
        end else begin
          state_nxt = IDLE;
        end
      end
      SETUP: begin
        state_nxt = STROBE;
        cnt_nxt   = STB_LOAD;
      end
      STROBE: begin
        if (cnt == '0) begin
          state_nxt = RELEASE;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      RELEASE: begin
        if (cnt == '0) begin
`ifdef TTL_ARB_VERIFY_EN
          state_nxt = VERIFY;
          cnt_nxt   = CNT_ONE;
`else
          state_nxt = DONE;
`endif
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
`ifdef TTL_ARB_VERIFY_EN
      VERIFY: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - CNT_ONE;
      end
`endif
      OE:     state_nxt = SAMPLE;
      SAMPLE: state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        ptr_nxt   = (owner == LAST_IDX) ? '0 : owner + PTR_ONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch strobes are registered from the next state so cen/OCn never glitch.
  always_comb begin
    owner_oh_nxt            = '0;
    owner_oh_nxt[owner_nxt] = 1'b1;
    gnt_st = (state_nxt != IDLE) && (state_nxt != ARB) && (state_nxt != DONE);
    cen_st = (state_nxt == STROBE);
    oe_st  = (state_nxt == OE) || (state_nxt == SAMPLE);
`ifdef TTL_ARB_VERIFY_EN
    if (state_nxt == VERIFY) oe_st = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      done    <= '0;
      lat_cen <= '0;
      lat_OCn <= '1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      gnt     <= gnt_st ? owner_oh_nxt : '0;
      done    <= (state_nxt == DONE) ? owner_oh_nxt : '0;
      lat_cen <= cen_st ? owner_oh_nxt : '0;
      lat_OCn <= oe_st ? ~owner_oh_nxt : '1;
      busy    <= (state_nxt != IDLE);
    end
  end

  // bus_D is frozen from ARB until the next ARB; rdata captures at end of SAMPLE.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      bus_D <= '0;
      rdata <= '0;
    end else begin
      if ((state == ARB) && pick_vld) bus_D <= din_sel;
      if (state == SAMPLE)            rdata <= bus_Q;
    end
  end

`ifdef TTL_ARB_VERIFY_EN
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      err <= 1'b0;
    end else if ((state == VERIFY) && (cnt == '0) && (bus_Q != bus_D)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ttl_latch_bus_arbiter.sv
// Scoreboard bench for ttl_latch_bus_arbiter with an octal-latch bank model on the bus.
// Build with TTL_ARB_VERIFY_EN defined to also exercise the read-back verify path.
`timescale 1ns/1ps
module tb_ttl_latch_bus_arbiter;
  localparam int NREQ    = 4;
  localparam int STB_CYC = 2;
  localparam int GAP_CYC = 1;
`ifdef TTL_ARB_VERIFY_EN
  localparam int VFY_CYC = 2;
`else
  localparam int VFY_CYC = 0;
`endif
  localparam int WR_LAT = 4 + STB_CYC + GAP_CYC + VFY_CYC;
  localparam int RD_LAT = 5;

  logic              clk  = 1'b0;
  logic              RSTn = 1'b1;
  logic [NREQ-1:0]   req  = '0;
  logic [NREQ-1:0]   wr   = '0;
  logic [8*NREQ-1:0] din  = '0;
  logic [NREQ-1:0]   gnt, done, lat_cen, lat_OCn;
  logic [7:0]        rdata, bus_D, bus_Q;
  logic              busy;
`ifdef TTL_ARB_VERIFY_EN
  logic              err;
`endif

  typedef struct {
    int         owner;
    bit         is_wr;
    logic [7:0] data;
    logic [7:0] wdata;
    bit         first;
    bit         err;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         batch_start = 0;
  int         last_done   = 0;
  logic [7:0] lat_mem   [NREQ];
  logic [7:0] mem_model [NREQ];
  int         ptr_model = 0;
  bit         err_model = 1'b0;
  bit         stuck     = 1'b0;

  ttl_latch_bus_arbiter #(.NREQ(NREQ), .STB_CYC(STB_CYC), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .RSTn(RSTn), .req(req), .wr(wr), .din(din),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .bus_D(bus_D),
    .lat_cen(lat_cen), .lat_OCn(lat_OCn), .bus_Q(bus_Q)
`ifdef TTL_ARB_VERIFY_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    return 8'(8'h21 * (i + 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Latch bank: capture on cen rising, undriven outputs pull the shared Q bus high.
  initial begin : latch_model
    logic [NREQ-1:0] cen_prev;
    cen_prev = '0;
    for (int i = 0; i < NREQ; i++) lat_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (lat_cen[i] && !cen_prev[i]) lat_mem[i] = stuck ? 8'h00 : bus_D;
      cen_prev = lat_cen;
    end
  end

  always_comb begin
    bus_Q = 8'hFF;
    for (int i = 0; i < NREQ; i++)
      if (!lat_OCn[i]) bus_Q = bus_Q & lat_mem[i];
  end

  initial begin : monitor
    exp_t            e;
    logic [NREQ-1:0] oh;
    int              start;
    int              cen_cnt;
    int              oc_cnt;
    bit              rules;
    cen_cnt = 0;
    oc_cnt  = 0;
    forever begin
      @(negedge clk);
      if (!RSTn) begin
        cen_cnt = 0;
        oc_cnt  = 0;
      end else begin
        rules = ($countones(lat_cen) <= 1) && ($countones(~lat_OCn) <= 1) &&
                ($countones(gnt) <= 1) && !((|lat_cen) && !(&lat_OCn)) &&
                (busy || ((gnt == '0) && (lat_cen == '0) && (&lat_OCn)));
        check("bus_rules", 32'(rules), 32'(1));
        if ((gnt != '0) && (sb.size() > 0)) begin
          oh = '0;
          oh[sb[0].owner] = 1'b1;
          check("gnt_owner", 32'(gnt), 32'(oh));
        end
        if (|lat_cen) cen_cnt++;
        if (!(&lat_OCn)) oc_cnt++;
        if (|done) begin
          if (sb.size() == 0) begin
            check("spurious_done", 32'(done), 32'(0));
          end else begin
            e = sb.pop_front();
            oh = '0;
            oh[e.owner] = 1'b1;
            check("done_owner", 32'(done), 32'(oh));
            start = e.first ? batch_start : last_done + 2;
            check("latency", 32'(cyc - start + 2), 32'(e.is_wr ? WR_LAT : RD_LAT));
            if (e.is_wr) begin
              check("latch_q", 32'(lat_mem[e.owner]), 32'(e.data));
              check("bus_d", 32'(bus_D), 32'(e.wdata));
              check("cen_width", 32'(cen_cnt), 32'(STB_CYC));
              check("oe_width_wr", 32'(oc_cnt), 32'(VFY_CYC));
            end else begin
              check("rdata", 32'(rdata), 32'(e.data));
              check("cen_width_rd", 32'(cen_cnt), 32'(0));
              check("oe_width", 32'(oc_cnt), 32'(2));
            end
`ifdef TTL_ARB_VERIFY_EN
            check("err", 32'(err), 32'(e.err));
`endif
          end
          last_done = cyc;
          cen_cnt   = 0;
          oc_cnt    = 0;
        end
      end
    end
  end

  task automatic push_txn(input int i, input bit w, input logic [7:0] d, input bit first);
    exp_t e;
    e.owner = i;
    e.is_wr = w;
    e.wdata = d;
    e.first = first;
    if (w) begin
      mem_model[i] = stuck ? 8'h00 : d;
      if ((VFY_CYC > 0) && (mem_model[i] != d)) err_model = 1'b1;
    end
    e.data = mem_model[i];
    e.err  = err_model;
    sb.push_back(e);
  endtask

  // hold_n > 0: all requesters stay high for hold_n grants; otherwise each drops on its done.
  task automatic run_batch(input logic [NREQ-1:0] m, input logic [NREQ-1:0] w,
                           input logic [8*NREQ-1:0] d, input int hold_n, input bit drop_stb);
    int n_exp, t, seen, i, p, last;
    bit first;
    n_exp = 0; t = 0; seen = 0; first = 1'b1; p = ptr_model; last = p;
    while (busy && (t < 50)) begin @(negedge clk); t++; end
    if (hold_n > 0) begin
      for (int n = 0; n < hold_n; n++) begin
        i = (p + n) % NREQ;
        push_txn(i, w[i], d[8*i +: 8], first);
        first = 1'b0; n_exp++; last = i;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        i = (p + k) % NREQ;
        if (m[i]) begin
          push_txn(i, w[i], d[8*i +: 8], first);
          first = 1'b0; n_exp++; last = i;
        end
      end
    end
    ptr_model = (last + 1) % NREQ;
    wr = w; din = d; req = m;
    batch_start = cyc + 1;
    t = 0;
    while ((seen < n_exp) && (t < 400)) begin
      @(negedge clk); t++;
      if (drop_stb && (|lat_cen)) req = '0;
      if (|done) begin
        seen++;
        if (hold_n == 0) req = req & ~done;
        else if (seen >= hold_n) req = '0;
      end
    end
    if (seen < n_exp) begin
      check("timeout", 32'(seen), 32'(n_exp));
      req = '0;
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic reset_mid(input bit w);
    int t;
    t = 0;
    while (busy && (t < 50)) begin @(negedge clk); t++; end
    t = 0;
    wr = w ? 4'b1000 : 4'b0000;
    din = {mem_model[3], 24'h0};
    req = 4'b1000;
    while ((t < 40) && (w ? (lat_cen[3] != 1'b1) : (lat_OCn[3] != 1'b0))) begin
      @(negedge clk); t++;
    end
    check(w ? "mid_strobe_reached" : "mid_oe_reached",
          32'(w ? lat_cen[3] : !lat_OCn[3]), 32'(1));
    #2 RSTn = 1'b0;
    req = '0;
    #1;
    check("rst_cen", 32'(lat_cen), 32'(0));
    check("rst_ocn", 32'(lat_OCn), 32'(4'hF));
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    ptr_model = 0;
    err_model = 1'b0;
    @(negedge clk);
    RSTn = 1'b1;
    @(negedge clk);
  endtask

  initial begin : stimulus
    logic [NREQ-1:0]   m, w;
    logic [8*NREQ-1:0] d;
    for (int i = 0; i < NREQ; i++) mem_model[i] = init_val(i);
    #1 RSTn = 1'b0;
    #3;
    check("reset_gnt", 32'(gnt), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_cen", 32'(lat_cen), 32'(0));
    check("reset_ocn", 32'(lat_OCn), 32'(4'hF));
    check("reset_bus_d", 32'(bus_D), 32'(0));
    check("reset_rdata", 32'(rdata), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
`ifdef TTL_ARB_VERIFY_EN
    check("reset_err", 32'(err), 32'(0));
`endif
    repeat (2) @(negedge clk);
    RSTn = 1'b1;
    @(negedge clk);

    run_batch(4'b0100, 4'b0100, 32'h00A5_0000, 0, 1'b0);
    run_batch(4'b0010, 4'b0010, 32'h0000_3C00, 0, 1'b0);
    run_batch(4'b0010, 4'b0000, 32'h0000_0000, 0, 1'b0);
    reset_mid(1'b1);
    run_batch(4'b1111, 4'b0101, 32'h1122_3344, 5, 1'b0);
    run_batch(4'b0001, 4'b0001, 32'h0000_00C3, 0, 1'b1);
    reset_mid(1'b0);

    for (int n = 0; n < 40; n++) begin
      m = NREQ'($urandom_range(1, 15));
      w = NREQ'($urandom);
      d = (8*NREQ)'($urandom);
      if ($urandom_range(0, 4) == 0) run_batch(4'b1111, w, d, $urandom_range(2, 6), 1'b0);
      else run_batch(m, w, d, 0, 1'b0);
    end

`ifdef TTL_ARB_VERIFY_EN
    stuck = 1'b1;
    run_batch(4'b0010, 4'b0010, 32'h0000_FF00, 0, 1'b0);
    stuck = 1'b0;
    run_batch(4'b0100, 4'b0100, 32'h005A_0000, 0, 1'b0);
    run_batch(4'b0100, 4'b0000, 32'h0000_0000, 0, 1'b0);
    check("err_sticky", 32'(err), 32'(1));
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
